ramb16_s1_s36_fifo_ctrl: RTL and testbench

Controller that turns one dual-port 16 Kbit block RAM in the 16384x1 / 512x36 aspect into a 32-bit-in, 1-bit-out width-converting FIFO. 32-bit words are written through the RAM's wide port (port B). Bits are read LSB-first through the RAM's 1-bit port (port A) and presented on a valid/ready serial stream at one bit per cycle sustained. The block sits between a word-oriented producer and a bit-serial consumer (line encoders, serializers). It drives a RAMB16_S1_S36 instance directly on a single clock shared by both RAM ports.

---
 rtl/ramb16_s1_s36_fifo_ctrl_if.sv | 20 ++
 rtl/ramb16_s1_s36_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_ramb16_s1_s36_fifo_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ramb16_s1_s36_fifo_ctrl_if.sv
// Word-in / bit-out stream bundle for the RAMB16_S1_S36 width-converting FIFO.
// master drives words in and accepts bits out; slave is the FIFO controller.
interface ramb16_s1_s36_fifo_ctrl_if;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        out_valid;
    logic        out_bit;
    logic        out_ready;

    modport master (
        output wr_valid, wr_data, out_ready,
        input  wr_ready, out_valid, out_bit
    );

    modport slave (
        input  wr_valid, wr_data, out_ready,
        output wr_ready, out_valid, out_bit
    );
endinterface

// File: rtl/ramb16_s1_s36_fifo_ctrl.sv
// 32-bit-in, 1-bit-out FIFO built on one RAMB16_S1_S36: words go in through port B,
// bits come out LSB-first through port A into a 2-entry skid buffer.
module ramb16_s1_s36_fifo_ctrl #(
    parameter int AFULL_LEVEL = 448
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           flush,
    ramb16_s1_s36_fifo_ctrl_if.slave       bus,
    output logic [9:0]                     word_count,
    output logic                           almost_full,
    output logic                           empty,
    output logic [13:0]                    ram_addra,
    output logic                           ram_ena,
    input  logic                           ram_doa,
    output logic [8:0]                     ram_addrb,
    output logic                           ram_enb,
    output logic                           ram_web,
    output logic [31:0]                    ram_dib,
    output logic [3:0]                     ram_dipb
);

    logic [8:0]  wr_ptr_r;
    logic [13:0] rd_ptr_r;
    logic [9:0]  word_count_r;
    logic        inflight_r;
    logic        release_r;
    logic [1:0]  occ_r;
    logic [1:0]  buf_r;
    logic        almost_full_r;

    logic        wr_ready_s;
    logic        accept_s;
    logic        pop_s;
    logic        issue_s;
    logic [9:0]  word_count_n_s;
    logic [1:0]  occ_n_s;
    logic [1:0]  buf_n_s;

    // Handshakes and read issue; a word whose release is pending is no longer readable.
    always_comb begin
        wr_ready_s = (word_count_r < 10'd512) & ~flush;
        accept_s   = bus.wr_valid & wr_ready_s;
        pop_s      = (occ_r != 2'd0) & bus.out_ready;
        issue_s    = (word_count_r > {9'd0, release_r}) & ~flush &
                     (({1'b0, occ_r} + {2'd0, inflight_r}) < (3'd2 + {2'd0, pop_s}));
    end

    // Next word count: accept and release in the same cycle cancel out.
    always_comb begin
        word_count_n_s = word_count_r;
        case ({accept_s, release_r})
            2'b10:   word_count_n_s = word_count_r + 10'd1;
            2'b01:   word_count_n_s = word_count_r - 10'd1;
            default: word_count_n_s = word_count_r;
        endcase
    end

    // Output buffer next state: pop shifts the oldest out, returning RAM data appends.
    always_comb begin
        buf_n_s = buf_r;
        occ_n_s = occ_r;
        if (pop_s) begin
            buf_n_s = {1'b0, buf_r[1]};
            occ_n_s = occ_r - 2'd1;
        end else begin
            buf_n_s = buf_r;
            occ_n_s = occ_r;
        end
        if (inflight_r) begin
            if (occ_n_s == 2'd0) begin
                buf_n_s[0] = ram_doa;
            end else begin
                buf_n_s[1] = ram_doa;
            end
            occ_n_s = occ_n_s + 2'd1;
        end else begin
            occ_n_s = occ_n_s;
        end
    end

    // Controller state; flush wipes everything including a pending release and in-flight data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_r      <= 9'd0;
            rd_ptr_r      <= 14'd0;
            word_count_r  <= 10'd0;
            inflight_r    <= 1'b0;
            release_r     <= 1'b0;
            occ_r         <= 2'd0;
            buf_r         <= 2'd0;
            almost_full_r <= 1'b0;
        end else if (flush) begin
            wr_ptr_r      <= 9'd0;
            rd_ptr_r      <= 14'd0;
            word_count_r  <= 10'd0;
            inflight_r    <= 1'b0;
            release_r     <= 1'b0;
            occ_r         <= 2'd0;
            buf_r         <= 2'd0;
            almost_full_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + 9'd1;
            end
            if (issue_s) begin
                rd_ptr_r <= rd_ptr_r + 14'd1;
            end
            // Releasing one edge after the last bit is read keeps port B off the word port A reads.
            release_r     <= issue_s & (rd_ptr_r[4:0] == 5'd31);
            inflight_r    <= issue_s;
            word_count_r  <= word_count_n_s;
            occ_r         <= occ_n_s;
            buf_r         <= buf_n_s;
            almost_full_r <= (word_count_n_s >= 10'(AFULL_LEVEL));
        end
    end

    assign bus.wr_ready  = wr_ready_s;
    assign bus.out_valid = (occ_r != 2'd0);
    assign bus.out_bit   = buf_r[0];

    assign word_count  = word_count_r;
    assign almost_full = almost_full_r;
    assign empty       = (word_count_r == 10'd0) & (occ_r == 2'd0) & ~inflight_r;

    assign ram_ena   = issue_s & ~RST;
    assign ram_addra = rd_ptr_r;
    assign ram_enb   = accept_s & ~RST;
    assign ram_web   = accept_s & ~RST;
    assign ram_addrb = wr_ptr_r;
    assign ram_dib   = accept_s ? bus.wr_data : 32'd0;
    assign ram_dipb  = 4'd0;

endmodule

// File: tb/tb_ramb16_s1_s36_fifo_ctrl.sv
// Randomized scoreboard bench for ramb16_s1_s36_fifo_ctrl with a behavioural RAMB16_S1_S36 model.
module tb_ramb16_s1_s36_fifo_ctrl;
    localparam int AFULL = 448;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        flush = 1'b0;
    logic [9:0]  word_count;
    logic        almost_full, empty;
    logic [13:0] ram_addra;
    logic        ram_ena, ram_enb, ram_web;
    logic        ram_doa = 1'b0;
    logic [8:0]  ram_addrb;
    logic [31:0] ram_dib;
    logic [3:0]  ram_dipb;

    ramb16_s1_s36_fifo_ctrl_if bus();

    ramb16_s1_s36_fifo_ctrl #(.AFULL_LEVEL(AFULL)) dut (
        .CLK(CLK), .RST(RST), .flush(flush), .bus(bus),
        .word_count(word_count), .almost_full(almost_full), .empty(empty),
        .ram_addra(ram_addra), .ram_ena(ram_ena), .ram_doa(ram_doa),
        .ram_addrb(ram_addrb), .ram_enb(ram_enb), .ram_web(ram_web),
        .ram_dib(ram_dib), .ram_dipb(ram_dipb)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];
    int popped_total = 0;
    int bwrites = 0;
    logic mem [0:16383];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // RAM model: 512x32 write port B, 16384x1 registered read port A
    always @(posedge CLK) begin
        if (ram_enb && ram_web)
            for (int i = 0; i < 32; i++) mem[{ram_addrb, 5'd0} + 14'(i)] <= ram_dib[i];
        if (ram_ena) ram_doa <= mem[ram_addra];
    end

    // Stimulus observer: every accepted word pushes its 32 bits, LSB first
    always @(negedge CLK) begin
        if (RST || flush) begin
            exp_q.delete();
        end else if (bus.wr_valid && bus.wr_ready) begin
            for (int i = 0; i < 32; i++) exp_q.push_back(bus.wr_data[i]);
        end
    end

    // Monitor: compare every popped bit, count port B writes, watch for same-word collisions
    always @(negedge CLK) begin
        if (ram_enb && ram_web) bwrites++;
        if (ram_ena && ram_enb && (ram_addra[13:5] == ram_addrb)) begin
            checks++; errors++;
            $display("FAIL collision addra=%0h addrb=%0h", ram_addra, ram_addrb);
        end
        if (RST || flush) begin
            popped_total = 0;
        end else if (bus.out_valid && bus.out_ready) begin
            popped_total++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL extra_bit actual=%0b expected=none", bus.out_bit);
            end else begin
                chk("out_bit", 32'(bus.out_bit), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_reset_values();
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_bit", 32'(bus.out_bit), 32'd0);
        chk("rst_word_count", 32'(word_count), 32'd0);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_ram_en", {29'd0, ram_ena, ram_enb, ram_web}, 32'd0);
        chk("rst_addr", {9'd0, ram_addra, ram_addrb}, 32'd0);
        chk("rst_dib", ram_dib, 32'd0);
    endtask

    task automatic drain(input string name, input int limit);
        int n;
        bus.wr_valid = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (!(empty && exp_q.size() == 0) && n < limit) begin
            step();
            n++;
        end
        chk({name, "_empty"}, 32'(empty), 32'd1);
        chk({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n_acc, cyc, hi, pops, gaps, rise_pops;
        bit acc, rise_seen;
        bus.wr_valid = 1'b0;
        bus.wr_data = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        check_reset_values();
        RST = 1'b0;
        step();

        // single word: latency, bit order, no gaps, empty afterwards
        bus.out_ready = 1'b1;
        bus.wr_valid = 1'b1;
        bus.wr_data = 32'h8000_0001;
        step();
        bus.wr_valid = 1'b0;
        chk("lat_t1_valid", 32'(bus.out_valid), 32'd0);
        chk("lat_t1_issue", 32'(ram_ena), 32'd1);
        step();
        chk("lat_t2_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("lat_first_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_first_bit", 32'(bus.out_bit), 32'd1);
        hi = 0;
        while (bus.out_valid && hi < 40) begin
            hi++;
            step();
        end
        chk("word1_run_len", 32'(hi), 32'd32);
        chk("word1_empty", 32'(empty), 32'd1);

        // fill to 512 words with consumer stalled
        bus.out_ready = 1'b0;
        bwrites = 0;
        n_acc = 0;
        cyc = 0;
        while (n_acc < 512 && cyc < 700) begin
            bus.wr_valid = 1'b1;
            bus.wr_data = $urandom;
            @(negedge CLK);
            acc = bus.wr_ready;
            step();
            cyc++;
            if (acc) n_acc++;
            chk("fill_count", 32'(word_count), 32'(n_acc));
            chk("fill_afull", 32'(almost_full), 32'(n_acc >= AFULL));
        end
        repeat (3) step();
        chk("full_wr_ready", 32'(bus.wr_ready), 32'd0);
        chk("full_count", 32'(word_count), 32'd512);
        chk("full_bwrites", 32'(bwrites), 32'd512);
        chk("stall_buffered", 32'(exp_q.size()), 32'(512 * 32));
        bus.wr_valid = 1'b0;

        // drain from full: gap-free stream, wr_ready returns after the first word is released
        bus.out_ready = 1'b1;
        pops = 0; gaps = 0; rise_pops = -1; rise_seen = 1'b0; cyc = 0;
        while (pops < 16384 && cyc < 17000) begin
            @(negedge CLK);
            if (!rise_seen && bus.wr_ready) begin
                rise_seen = 1'b1;
                rise_pops = pops;
            end
            if (bus.out_valid) pops++;
            else gaps++;
            @(posedge CLK);
            #1;
            cyc++;
        end
        chk("drain_pops", 32'(pops), 32'd16384);
        chk("drain_gaps", 32'(gaps), 32'd0);
        chk("wr_ready_rise", 32'(rise_pops >= 30 && rise_pops <= 34), 32'd1);
        step();
        step();
        chk("drain_done_empty", 32'(empty), 32'd1);
        chk("rd_ptr_wrap", 32'(ram_addra), 32'(popped_total % 16384));

        // random traffic: write every cycle, random consumer
        for (int i = 0; i < 10000; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data = $urandom;
            bus.out_ready = $urandom_range(0, 1);
            step();
        end
        drain("random", 20000);

        // flush with a read in flight behind a buffered bit
        bus.wr_valid = 1'b1;
        bus.wr_data = $urandom;
        step();
        bus.wr_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (4) step();
        chk("pre_flush_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 32'(bus.out_valid), 32'd0);
        chk("flush_count", 32'(word_count), 32'd0);
        chk("flush_empty", 32'(empty), 32'd1);
        step();
        chk("flush_dropped", 32'(bus.out_valid), 32'd0);
        bus.wr_valid = 1'b1;
        bus.wr_data = $urandom;
        step();
        drain("post_flush", 200);
        chk("post_flush_bits", 32'(popped_total), 32'd32);

        // async reset mid-stream
        bus.wr_valid = 1'b1;
        bus.wr_data = $urandom;
        repeat (3) step();
        bus.wr_data = $urandom;
        step();
        #2;
        RST = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_ena", 32'(ram_ena), 32'd0);
        chk("arst_enb", 32'(ram_enb), 32'd0);
        bus.wr_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) step();
        RST = 1'b0;
        step();
        check_reset_values();
        bus.wr_valid = 1'b1;
        bus.wr_data = $urandom;
        step();
        drain("post_reset", 200);
        chk("post_reset_bits", 32'(popped_total), 32'd32);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
